gunfight_audio: RTL and testbench

// - Gun Fight sound generator; sits between the invaderst CPU core and the two 8-bit sigma-delta dac instances.
// - Converts the SoundCtrl3/SoundCtrl5 latch bits into stereo gunshot (noise burst) and hit (square tone) voices.
// - Left player's shot sounds in the left channel and the right player's in the right; it replaces invaders_audio for this core.

---
 rtl/gunfight_audio_pkg.sv | 33 +++
 rtl/gunfight_shot_voice.sv | 71 +++++++
 rtl/gunfight_audio.sv | 127 ++++++++++++
 tb/tb_gunfight_audio.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gunfight_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gunfight_audio_pkg
// Purpose  : Shared types and constants for the Gun Fight sound generator.
// Revision : 1.0 - initial release
// ============================================================================
package gunfight_audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ATTACK = 2'd1,
    DECAY  = 2'd2
  } shot_state_t;

  // 17-bit Fibonacci LFSR, taps 17 and 14 (zero-based bit indices 16 and 13)
  localparam logic [16:0] LFSR_SEED  = 17'h1_FFFF;
  localparam int          LFSR_TAP_A = 16;
  localparam int          LFSR_TAP_B = 13;

  localparam int SC3_SHOT_L = 0;
  localparam int SC3_SHOT_R = 1;
  localparam int SC3_HIT_L  = 2;
  localparam int SC3_HIT_R  = 3;
  localparam int SC5_ENABLE = 5;

  localparam logic [7:0] HIT_AMP = 8'h60;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gunfight_shot_voice.sv
`default_nettype none
// ============================================================================
// Module   : gunfight_shot_voice
// Purpose  : Noise-burst gunshot voice with a fast exponential decay envelope.
// Revision : 1.0 - initial release
// ============================================================================
module gunfight_shot_voice
  import gunfight_audio_pkg::*;
#(
  parameter int DECAY_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_trig,
  input  logic       i_noise,
  output logic [7:0] o_sample
);

  shot_state_t r_state;
  shot_state_t w_state_nxt;
  logic [7:0]  r_env;
  logic [7:0]  w_env_nxt;
  logic [7:0]  w_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_env   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_keep      = r_env - (r_env >> DECAY_SHIFT);
    if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (i_trig) w_state_nxt = ATTACK;
        end
        ATTACK: begin
          w_env_nxt   = 8'hFF;
          w_state_nxt = DECAY;
        end
        DECAY: begin
          if (i_trig) begin
            w_state_nxt = ATTACK;
          end else if (w_keep <= 8'd1) begin
            // the -1 would hit or cross zero: burst is over
            w_env_nxt   = 8'h00;
            w_state_nxt = IDLE;
          end else begin
            w_env_nxt = w_keep - 8'd1;
          end
        end
        default: begin
          w_env_nxt   = 8'h00;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign o_sample = i_noise ? r_env : 8'h00;

endmodule
`default_nettype wire

// File: rtl/gunfight_audio.sv
`default_nettype none
// ============================================================================
// Module   : gunfight_audio
// Purpose  : Gun Fight stereo sound generator (gunshot noise bursts, hit tones).
// Revision : 1.0 - initial release
// ============================================================================
module gunfight_audio
  import gunfight_audio_pkg::*;
#(
  parameter int SAMPLE_DIV  = 250,
  parameter int DECAY_SHIFT = 4,
  parameter int HIT_HALF    = 50,
  parameter int HIT_TICKS   = 8000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [5:0] sound_ctrl3,
  input  logic [5:0] sound_ctrl5,
  output logic [7:0] audio_l,
  output logic [7:0] audio_r
);

  localparam int                DIV_W      = $clog2(SAMPLE_DIV);
  localparam int                PH_W       = $clog2(HIT_HALF);
  localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]   c_ph_last  = PH_W'(HIT_HALF - 1);
  localparam logic [13:0]       c_hit_load = 14'(HIT_TICKS - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  logic             r_tick_d;
  logic [16:0]      r_lfsr;
  logic [3:0]       r_sc3;
  logic [3:0]       r_sc3_prev;
  logic             r_enable;
  logic [3:0]       r_pend;
  logic [3:0]       w_rise;
  logic [3:0]       w_trig;
  logic [7:0]       w_out [2];
  logic             w_unused;

  assign w_unused = ^{sound_ctrl3[5:4], sound_ctrl5[4:0]};
  assign w_tick   = (r_div_cnt == c_div_last);
  assign w_rise   = r_sc3 & ~r_sc3_prev;
  // an edge arriving in the tick cycle is consumed by that same tick
  assign w_trig   = r_pend | w_rise;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_tick_d   <= 1'b0;
      r_lfsr     <= LFSR_SEED;
      r_sc3      <= 4'h0;
      r_sc3_prev <= 4'h0;
      r_enable   <= 1'b0;
      r_pend     <= 4'h0;
    end else begin
      r_div_cnt  <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_tick_d   <= w_tick;
      r_sc3      <= sound_ctrl3[3:0];
      r_sc3_prev <= r_sc3;
      r_enable   <= sound_ctrl5[SC5_ENABLE];
      r_pend     <= w_tick ? 4'h0 : (r_pend | w_rise);
      if (w_tick) r_lfsr <= {r_lfsr[15:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_side
    logic [7:0]      w_shot;
    logic [7:0]      w_hit;
    logic            w_hit_on;
    logic [13:0]     r_hit_cnt;
    logic [PH_W-1:0] r_hit_ph;
    logic            r_hit_sq;
    logic [7:0]      r_audio;

    gunfight_shot_voice #(
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_shot (
      .clk      (clk_sys),
      .rst      (reset),
      .i_tick   (w_tick),
      .i_trig   (w_trig[SC3_SHOT_L + s]),
      .i_noise  (r_lfsr[0]),
      .o_sample (w_shot)
    );

    assign w_hit_on = (r_hit_cnt != 14'd0);

    // phase only restarts from silence; a retrigger just extends the tone
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_hit_cnt <= 14'd0;
        r_hit_ph  <= '0;
        r_hit_sq  <= 1'b0;
      end else if (w_tick && (w_trig[SC3_HIT_L + s] || w_hit_on)) begin
        r_hit_cnt <= w_trig[SC3_HIT_L + s] ? c_hit_load : r_hit_cnt - 14'd1;
        if (!w_hit_on) begin
          r_hit_ph <= '0;
          r_hit_sq <= 1'b1;
        end else if (r_hit_ph == c_ph_last) begin
          r_hit_ph <= '0;
          r_hit_sq <= ~r_hit_sq;
        end else begin
          r_hit_ph <= r_hit_ph + PH_W'(1);
        end
      end
    end

    assign w_hit = (w_hit_on && r_hit_sq) ? HIT_AMP : 8'h00;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        r_audio <= 8'h00;
      end else if (r_tick_d) begin
        r_audio <= r_enable ? sat8({1'b0, w_shot} + {1'b0, w_hit}) : 8'h00;
      end
    end

    assign w_out[s] = r_audio;
  end

  assign audio_l = w_out[0];
  assign audio_r = w_out[1];

endmodule
`default_nettype wire

// File: tb/tb_gunfight_audio.sv
`default_nettype none
// ============================================================================
// Module   : tb_gunfight_audio
// Purpose  : Directed self-checking bench for gunfight_audio.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gunfight_audio;

  localparam int DIV = 4;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [5:0] sound_ctrl3;
  logic [5:0] sound_ctrl5;
  logic [7:0] audio_l;
  logic [7:0] audio_r;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc;
  logic [16:0] m_lfsr;

  gunfight_audio #(
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .sound_ctrl3 (sound_ctrl3),
    .sound_ctrl5 (sound_ctrl5),
    .audio_l     (audio_l),
    .audio_r     (audio_r)
  );

  always #5 clk_sys = ~clk_sys;

  // edges since reset release; ticks land on multiples of DIV
  always @(posedge clk_sys or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] lfsr_step(input logic [16:0] s);
    return {s[15:0], s[16] ^ s[13]};
  endfunction

  function automatic logic [7:0] env_dec(input logic [7:0] e);
    logic [7:0] k;
    k = e - (e >> 4);
    return (k <= 8'd1) ? 8'h00 : k - 8'd1;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int shot_out(input logic [7:0] e);
    return m_lfsr[0] ? int'(e) : 0;
  endfunction

  // advance to the sampling point just after the next output update
  task automatic upd();
    do @(negedge clk_sys); while (cyc % DIV != 1);
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic pulse(input logic [5:0] bits);
    sound_ctrl3 = bits;
    @(negedge clk_sys);
    sound_ctrl3 = 6'h00;
  endtask

  // wait until the FF and EF updates of a fresh burst will both see noise = 1
  task automatic find_window();
    logic [16:0] a, b, c;
    for (int k = 0; k < 200; k++) begin
      a = lfsr_step(m_lfsr);
      b = lfsr_step(a);
      c = lfsr_step(b);
      if (b[0] && c[0]) break;
      upd();
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_value({tag, "_l"}, audio_l, 0);
    check_value({tag, "_r"}, audio_r, 0);
    repeat (3) @(negedge clk_sys);
    reset  = 1'b0;
    m_lfsr = 17'h1_FFFF;
    @(negedge clk_sys);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1);
  end

  initial begin
    int         bad;
    int         exp;
    logic [7:0] env;

    reset       = 1'b1;
    sound_ctrl3 = 6'h00;
    sound_ctrl5 = 6'h20;
    repeat (3) @(negedge clk_sys);
    check_value("rst_l", audio_l, 0);
    check_value("rst_r", audio_r, 0);
    reset  = 1'b0;
    m_lfsr = 17'h1_FFFF;
    @(negedge clk_sys);

    // right hit armed before the first tick; first update lands at edge DIV+1
    sound_ctrl3 = 6'h08;
    repeat (DIV - 1) @(negedge clk_sys);
    check_value("pre_first_tick_r", audio_r, 0);
    @(negedge clk_sys);
    m_lfsr = lfsr_step(m_lfsr);
    check_value("first_tick_r", audio_r, 'h60);
    check_value("first_tick_l", audio_l, 0);
    sound_ctrl3 = 6'h00;

    bad = 0;
    for (int n = 2; n <= 8010; n++) begin
      upd();
      exp = (n <= 7999 && ((n - 1) / 50) % 2 == 0) ? 'h60 : 0;
      if (audio_r !== exp[7:0] || audio_l !== 8'h00) bad++;
      if (n == 50)   check_value("hit_high_last", audio_r, 'h60);
      if (n == 51)   check_value("hit_low_first", audio_r, 0);
      if (n == 101)  check_value("hit_high_again", audio_r, 'h60);
      if (n == 7950) check_value("hit_high_late", audio_r, 'h60);
      if (n == 8000) check_value("hit_silent", audio_r, 0);
    end
    check_value("hit_pattern", bad, 0);

    // left shot: attack, FF, EF, then decay to silence
    find_window();
    pulse(6'h01);
    upd();
    check_value("shot_attack_l", audio_l, 0);
    upd();
    check_value("shot_ff_l", audio_l, shot_out(8'hFF));
    check_value("shot_ff_r", audio_r, 0);
    upd();
    check_value("shot_ef_l", audio_l, shot_out(8'hEF));
    env = 8'hEF;
    bad = 0;
    for (int n = 4; n <= 100; n++) begin
      env = env_dec(env);
      upd();
      if (audio_l !== shot_out(env) || audio_r !== 8'h00) bad++;
    end
    check_value("shot_burst", bad, 0);

    // retrigger while the envelope sits at 0x40
    find_window();
    pulse(6'h01);
    upd();
    upd();
    env = 8'hFF;
    bad = 0;
    for (int n = 0; n < 60 && env != 8'h40; n++) begin
      env = env_dec(env);
      upd();
      if (audio_l !== shot_out(env)) bad++;
    end
    check_value("retrig_env40", env, 'h40);
    pulse(6'h01);
    upd();
    check_value("retrig_attack", audio_l, shot_out(8'h40));
    upd();
    check_value("retrig_ff", audio_l, shot_out(8'hFF));
    env = 8'hFF;
    for (int n = 0; n < 80; n++) begin
      env = env_dec(env);
      upd();
      if (audio_l !== shot_out(env)) bad++;
    end
    check_value("retrig_burst", bad, 0);

    // held-high trigger gives one burst only
    sound_ctrl3 = 6'h01;
    env = 8'h00;
    bad = 0;
    for (int n = 1; n <= 1000; n++) begin
      upd();
      if (n == 2)      env = 8'hFF;
      else if (n > 2)  env = env_dec(env);
      if (audio_l !== shot_out(env)) bad++;
    end
    check_value("held_one_burst", bad, 0);
    sound_ctrl3 = 6'h00;
    upd();

    // saturation with left shot + left hit, then mute and resume
    find_window();
    pulse(6'h05);
    upd();
    check_value("sat_attack", audio_l, 'h60);
    upd();
    check_value("sat_ff", audio_l, 'hFF);
    upd();
    check_value("sat_ef", audio_l, 'hFF);
    sound_ctrl5 = 6'h00;
    env = env_dec(8'hEF);
    upd();
    check_value("mute_l", audio_l, 0);
    sound_ctrl5 = 6'h20;
    env = env_dec(env);
    upd();
    check_value("resume_l", audio_l, sat(shot_out(env) + 'h60));

    // asynchronous reset in the middle of a sample period
    @(negedge clk_sys);
    #2;
    do_reset("mid_reset");

    // edges on both shots land in the tick cycle itself
    @(negedge clk_sys);
    sound_ctrl3 = 6'h03;
    @(negedge clk_sys);
    sound_ctrl3 = 6'h00;
    upd();
    check_value("sim_attack_l", audio_l, 0);
    check_value("sim_attack_r", audio_r, 0);
    env = 8'h00;
    bad = 0;
    for (int n = 2; n <= 60; n++) begin
      upd();
      env = (n == 2) ? 8'hFF : env_dec(env);
      if (audio_l !== shot_out(env) || audio_r !== shot_out(env)) bad++;
    end
    check_value("sim_lr_burst", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
